max7219_serial_rx: RTL and testbench
====================================

// Module: max7219_serial_rx
// PURPOSE
//  Receive side of the MAX7219 3-wire serial link (LOAD/DIN/CLK) driven by max7219_if.
//  Oversamples the link on the system clock and deserializes daisy-chained 16-bit frames.
//  Emits one decoded frame per cascaded matrix after each LOAD rising edge.
//  Sits in the MAX7219 bench/checker path behind the interface transmitter, ahead of the matrix model.
// PARAMETERS
//  G_NB_MATRIX    8  number of cascaded MAX7219 devices; valid range 1..16
//  G_SYNC_STAGES  2  input synchronizer depth; valid range >= 2
//  G_IDX_WIDTH    3  width of o_frame_idx; must satisfy 2**G_IDX_WIDTH >= G_NB_MATRIX
// PORTS
//  clk             in   1   system clock
//  rst_n           in   1   asynchronous reset, active low
//  i_max7219_clk   in   1   serial clock from the link (asynchronous to clk)
//  i_max7219_din   in   1   serial data from the link, MSB first
//  i_max7219_load  in   1   latch strobe from the link; rising edge commits the chain
//  o_frame_valid   out  1   one-cycle strobe; o_frame_* fields are valid in this cycle
//  o_frame_idx     out  G_IDX_WIDTH  matrix index, 0 = device nearest DIN
//  o_frame_addr    out  4   frame bits D11..D8 (register address)
//  o_frame_data    out  8   frame bits D7..D0
//  o_busy          out  1   high while the emit FSM is in EMIT
//  o_bit_cnt_err   out  1   one-cycle pulse on LOAD rise when bit count != 16*G_NB_MATRIX
//  o_overrun       out  1   one-cycle pulse when LOAD rises while o_busy = 1
// BEHAVIOUR
//  Reset (async, rst_n = 0) sets:
//   - all outputs to 0
//   - synchronizer stages to 0
//   - shift register, snapshot and bit counter to 0
//   - FSM to IDLE
//  Input capture:
//   - clk, din and load each pass through G_SYNC_STAGES flops.
//   - An edge detector follows the synchronized clk and load.
//   - din uses the same synchronizer depth, so it stays aligned with clk.
//  Shifting on each synchronized CLK rising edge:
//   - sr <= {sr[16*N-2:0], din}, width 16*G_NB_MATRIX.
//   - The bit counter increments and saturates at 16*N+1.
//   - Shifting happens regardless of the LOAD level, as in the real device.
//  On a synchronized LOAD rising edge:
//   - snap <= sr; the bit counter clears.
//   - o_bit_cnt_err pulses if the counter was != 16*N.
//   - The frames are still emitted, matching the device, which latches regardless of count.
//  FSM:
//   - IDLE -> EMIT on LOAD rise; idx <= 0.
//   - EMIT: o_frame_valid = 1 every cycle.
//   - Fields for each frame, with k = idx:
//     - o_frame_idx = k
//     - o_frame_addr = snap[16k+11 : 16k+8]
//     - o_frame_data = snap[16k+7 : 16k]
//   - idx increments each cycle. EMIT -> IDLE after idx = N-1.
//   - Emission takes exactly N cycles.
//  Latency: first o_frame_valid occurs G_SYNC_STAGES+2 clk cycles after LOAD rises at the pin.
//  Bits D15..D12 are discarded.
//  Simultaneous events:
//   - CLK rise and LOAD rise in the same cycle: shift first, then snapshot, so the snapshot includes the new bit.
//   - LOAD rise during EMIT: o_overrun pulses and the snapshot reloads; idx restarts at 0.
//     The interrupted sequence is abandoned.
//  Reset mid-frame or mid-emit: state is dropped immediately; no partial o_frame_valid after release.
//  Link timing: CLK high and low phases must each be >= G_SYNC_STAGES+1 clk cycles.
//  Faster links are unsupported and are not detected.
// TESTING
//  1. N=8; send 128 bits:
//     - frames 0x0C01 for matrices 7..1, then 0x0A05 for matrix 0.
//     - LOAD rise -> 8 consecutive valids.
//     - idx0 gives addr=0xA, data=0x05; idx1..7 give addr=0xC, data=0x01.
//     - no error pulses.
//  2. Send 120 bits then LOAD -> o_bit_cnt_err=1 for one cycle and 8 frames are emitted.
//     - frame idx7 holds the leftover old bits.
//  3. Send 0xF3AB as the last 16 bits -> idx0 gives addr=0x3, data=0xAB; the 0xF nibble is ignored.
//  4. Second LOAD rise 3 cycles into EMIT -> o_overrun pulse, then a fresh 8-frame burst starting at idx0.
//  5. Assert rst_n=0 after 64 bits, release, send a full 128-bit chain, then LOAD:
//     - outputs stay 0 during reset.
//     - counter behaviour proves the count restarted from 0; no o_bit_cnt_err.
//  6. Back-to-back chains from max7219_if (G_MAX_HALF_PERIOD=4):
//     - every transmitted word is recovered bit-exact on the matching idx.

Source files
------------

// File: rtl/max7219_serial_rx_if.sv
// ---------------------------------------------------------------------------
// max7219_serial_rx_if
//   Three-wire MAX7219 serial link (LOAD/DIN/CLK) as seen between the link
//   transmitter and the receiver.
//   i_max7219_clk   serial clock, asynchronous to the receiver system clock
//   i_max7219_din   serial data, MSB first
//   i_max7219_load  latch strobe, rising edge commits the chain
//   modport master : drives the link (transmitter / testbench)
//   modport slave  : samples the link (receiver)
// ---------------------------------------------------------------------------
interface max7219_serial_rx_if;
  logic i_max7219_clk;
  logic i_max7219_din;
  logic i_max7219_load;

  modport master (
    output i_max7219_clk,
    output i_max7219_din,
    output i_max7219_load
  );

  modport slave (
    input i_max7219_clk,
    input i_max7219_din,
    input i_max7219_load
  );
endinterface

// File: rtl/max7219_serial_rx.sv
// ---------------------------------------------------------------------------
// max7219_serial_rx
//   Oversamples the MAX7219 3-wire link on clk, deserializes the daisy chain
//   of 16-bit frames and, after every LOAD rising edge, emits one decoded
//   frame per cascaded device on consecutive cycles (idx 0 = nearest DIN).
// Ports
//   clk, rst_n      system clock, asynchronous active-low reset
//   link            serial link (slave modport)
//   o_frame_valid   one-cycle strobe qualifying o_frame_idx/addr/data
//   o_frame_idx     device index of the emitted frame
//   o_frame_addr    frame bits D11..D8
//   o_frame_data    frame bits D7..D0
//   o_busy          high while frames are being emitted
//   o_bit_cnt_err   pulse on LOAD rise when bit count != 16*G_NB_MATRIX
//   o_overrun       pulse when LOAD rises while still emitting
// ---------------------------------------------------------------------------
module max7219_serial_rx #(
  parameter int G_NB_MATRIX   = 8,
  parameter int G_SYNC_STAGES = 2,
  parameter int G_IDX_WIDTH   = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  max7219_serial_rx_if.slave     link,
  output logic                   o_frame_valid,
  output logic [G_IDX_WIDTH-1:0] o_frame_idx,
  output logic [3:0]             o_frame_addr,
  output logic [7:0]             o_frame_data,
  output logic                   o_busy,
  output logic                   o_bit_cnt_err,
  output logic                   o_overrun
);

  localparam int CHAIN_W = 16 * G_NB_MATRIX;
  // D15..D12 of the farthest device are never observed, so they are not stored.
  localparam int SR_W    = CHAIN_W - 4;
  localparam int SNAP_W  = 12 * G_NB_MATRIX;
  localparam int CNT_W   = $clog2(CHAIN_W + 2);

  localparam logic [CNT_W-1:0]       CNT_FULL = CNT_W'(CHAIN_W);
  localparam logic [CNT_W-1:0]       CNT_SAT  = CNT_W'(CHAIN_W + 1);
  localparam logic [G_IDX_WIDTH-1:0] IDX_LAST = G_IDX_WIDTH'(G_NB_MATRIX - 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_EMIT = 1'b1;

  logic [G_SYNC_STAGES-1:0] clk_sync_r;
  logic [G_SYNC_STAGES-1:0] din_sync_r;
  logic [G_SYNC_STAGES-1:0] load_sync_r;
  logic                     clk_prev_r;
  logic                     load_prev_r;
  logic [SR_W-1:0]          sr_r;
  logic [SNAP_W-1:0]        snap_r;
  logic [CNT_W-1:0]         cnt_r;
  logic [0:0]               state_r;
  logic [G_IDX_WIDTH-1:0]   idx_r;

  logic                     clk_rise_s;
  logic                     load_rise_s;
  logic                     din_s;
  logic [SR_W-1:0]          sr_next_s;
  logic [CNT_W-1:0]         cnt_next_s;
  logic [3:0]               addr_s;
  logic [7:0]               data_s;

  assign clk_rise_s  = clk_sync_r[G_SYNC_STAGES-1] & ~clk_prev_r;
  assign load_rise_s = load_sync_r[G_SYNC_STAGES-1] & ~load_prev_r;
  assign din_s       = din_sync_r[G_SYNC_STAGES-1];
  assign o_busy      = (state_r == ST_EMIT);

  // Synchronizers and edge-detect history for the asynchronous link inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync_r  <= '0;
      din_sync_r  <= '0;
      load_sync_r <= '0;
      clk_prev_r  <= 1'b0;
      load_prev_r <= 1'b0;
    end else begin
      clk_sync_r  <= {clk_sync_r[G_SYNC_STAGES-2:0], link.i_max7219_clk};
      din_sync_r  <= {din_sync_r[G_SYNC_STAGES-2:0], link.i_max7219_din};
      load_sync_r <= {load_sync_r[G_SYNC_STAGES-2:0], link.i_max7219_load};
      clk_prev_r  <= clk_sync_r[G_SYNC_STAGES-1];
      load_prev_r <= load_sync_r[G_SYNC_STAGES-1];
    end
  end

  // Next shift-register and bit-count values; a same-cycle LOAD rise sees these.
  always_comb begin
    sr_next_s  = sr_r;
    cnt_next_s = cnt_r;
    if (clk_rise_s) begin
      sr_next_s = {sr_r[SR_W-2:0], din_s};
      if (cnt_r == CNT_SAT) begin
        cnt_next_s = cnt_r;
      end else begin
        cnt_next_s = cnt_r + CNT_W'(1);
      end
    end else begin
      sr_next_s  = sr_r;
      cnt_next_s = cnt_r;
    end
  end

  // Shift register, bit counter and snapshot of the D11..D0 field of every frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_r   <= '0;
      cnt_r  <= '0;
      snap_r <= '0;
    end else begin
      sr_r <= sr_next_s;
      if (load_rise_s) begin
        cnt_r <= '0;
        for (int k = 0; k < G_NB_MATRIX; k++) begin
          snap_r[12*k +: 12] <= sr_next_s[16*k +: 12];
        end
      end else begin
        cnt_r <= cnt_next_s;
      end
    end
  end

  // Field select of the frame currently addressed by idx_r.
  always_comb begin
    addr_s = 4'h0;
    data_s = 8'h00;
    for (int k = 0; k < G_NB_MATRIX; k++) begin
      if (idx_r == G_IDX_WIDTH'(k)) begin
        addr_s = snap_r[12*k+8 +: 4];
        data_s = snap_r[12*k +: 8];
      end else begin
        addr_s = addr_s;
        data_s = data_s;
      end
    end
  end

  // Emit FSM: a LOAD rise always (re)starts a burst at idx 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      idx_r   <= '0;
    end else if (load_rise_s) begin
      state_r <= ST_EMIT;
      idx_r   <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_r <= ST_IDLE;
          idx_r   <= '0;
        end
        ST_EMIT: begin
          if (idx_r == IDX_LAST) begin
            state_r <= ST_IDLE;
            idx_r   <= '0;
          end else begin
            state_r <= ST_EMIT;
            idx_r   <= idx_r + G_IDX_WIDTH'(1);
          end
        end
        default: begin
          state_r <= ST_IDLE;
          idx_r   <= '0;
        end
      endcase
    end
  end

  // Registered outputs; the frame of an interrupted burst is dropped on a LOAD rise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_frame_valid <= 1'b0;
      o_frame_idx   <= '0;
      o_frame_addr  <= 4'h0;
      o_frame_data  <= 8'h00;
      o_bit_cnt_err <= 1'b0;
      o_overrun     <= 1'b0;
    end else begin
      o_frame_valid <= (state_r == ST_EMIT) && !load_rise_s;
      o_frame_idx   <= idx_r;
      o_frame_addr  <= addr_s;
      o_frame_data  <= data_s;
      o_bit_cnt_err <= load_rise_s && (cnt_next_s != CNT_FULL);
      o_overrun     <= load_rise_s && (state_r == ST_EMIT);
    end
  end

endmodule

// File: tb/tb_max7219_serial_rx.sv
// ---------------------------------------------------------------------------
// tb_max7219_serial_rx
//   Directed, table-driven bench for max7219_serial_rx (8 devices, 2 sync
//   stages). The link is bit-banged with a half period of 4 system clocks.
// ---------------------------------------------------------------------------
module tb_max7219_serial_rx;
  localparam int N  = 8;
  localparam int S  = 2;
  localparam int IW = 3;
  localparam int H  = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          o_frame_valid;
  logic [IW-1:0] o_frame_idx;
  logic [3:0]    o_frame_addr;
  logic [7:0]    o_frame_data;
  logic          o_busy;
  logic          o_bit_cnt_err;
  logic          o_overrun;

  max7219_serial_rx_if link ();

  max7219_serial_rx #(.G_NB_MATRIX(N), .G_SYNC_STAGES(S), .G_IDX_WIDTH(IW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .link          (link.slave),
    .o_frame_valid (o_frame_valid),
    .o_frame_idx   (o_frame_idx),
    .o_frame_addr  (o_frame_addr),
    .o_frame_data  (o_frame_data),
    .o_busy        (o_busy),
    .o_bit_cnt_err (o_bit_cnt_err),
    .o_overrun     (o_overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [127:0] bits;
    int           nbits;
    int           exp_err;
    logic [3:0]   a0;
    logic [7:0]   d0;
    logic [3:0]   a7;
    logic [7:0]   d7;
  } vec_t;

  int pass_cnt = 0;
  int chk_cnt  = 0;
  logic [127:0] exp_sr = '0;
  int load_cyc = 0;

  // Frame monitor, sampled on the falling edge.
  int v_idx[$];
  int v_addr[$];
  int v_data[$];
  int v_cyc[$];
  int err_n = 0;
  int ov_n  = 0;
  int ov_cyc = 0;

  always @(negedge clk) begin
    if (o_frame_valid === 1'b1) begin
      v_idx.push_back(int'(o_frame_idx));
      v_addr.push_back(int'(o_frame_addr));
      v_data.push_back(int'(o_frame_data));
      v_cyc.push_back(cyc);
    end
    if (o_bit_cnt_err === 1'b1) err_n++;
    if (o_overrun === 1'b1) begin
      ov_n++;
      ov_cyc = cyc;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_mon();
    v_idx.delete();
    v_addr.delete();
    v_data.delete();
    v_cyc.delete();
    err_n = 0;
    ov_n  = 0;
  endtask

  task automatic send_bit(input logic b);
    link.i_max7219_din = b;
    link.i_max7219_clk = 1'b0;
    tick(H);
    link.i_max7219_clk = 1'b1;
    tick(H);
    exp_sr = {exp_sr[126:0], b};
  endtask

  task automatic pulse_load();
    link.i_max7219_load = 1'b1;
    load_cyc = cyc;
    tick(H);
    link.i_max7219_load = 1'b0;
  endtask

  // Frame i of a burst against the model chain, with its cycle offset in the burst.
  function automatic logic [31:0] frame_word(input int i, input int off, input logic [15:0] w);
    return {8'(i), 4'(w[11:8]), 8'(w[7:0]), 12'(off)};
  endfunction

  task automatic check_burst(input string tag, input int exp_err);
    chk({tag, "_count"}, 32'(v_idx.size()), 32'd8);
    chk({tag, "_err"}, 32'(err_n), 32'(exp_err));
    chk({tag, "_ovr"}, 32'(ov_n), 32'd0);
    if (v_cyc.size() > 0) chk({tag, "_latency"}, 32'(v_cyc[0] - load_cyc), 32'(S + 2));
    else chk({tag, "_latency"}, 32'hFFFF_FFFF, 32'(S + 2));
    for (int i = 0; i < v_idx.size() && i < 8; i++) begin
      chk($sformatf("%s_frame%0d", tag, i),
          {8'(v_idx[i]), 4'(v_addr[i]), 8'(v_data[i]), 12'(v_cyc[i] - v_cyc[0])},
          frame_word(i, i, exp_sr[16*i +: 16]));
    end
  endtask

  vec_t vt[3];
  logic [15:0] exp_w[24];
  logic [15:0] lf;
  int old_n;

  initial begin
    vt[0] = '{{{7{16'h0C01}}, 16'h0A05}, 128, 0, 4'hA, 8'h05, 4'hC, 8'h01};
    vt[1] = '{{8'h00, 8'h1F, {7{16'h0B22}}}, 120, 1, 4'hB, 8'h22, 4'h5, 8'h1F};
    vt[2] = '{{{7{16'h0100}}, 16'hF3AB}, 128, 0, 4'h3, 8'hAB, 4'h1, 8'h00};

    link.i_max7219_clk  = 1'b0;
    link.i_max7219_din  = 1'b0;
    link.i_max7219_load = 1'b0;
    rst_n = 1'b0;
    tick(3);
    chk("reset_outputs",
        32'({o_frame_valid, o_frame_idx, o_frame_addr, o_frame_data, o_busy, o_bit_cnt_err, o_overrun}),
        32'd0);
    rst_n = 1'b1;
    tick(3);

    // Table: full chain, short chain (leftover bits in idx7), ignored D15..D12.
    for (int t = 0; t < 3; t++) begin
      clear_mon();
      for (int i = vt[t].nbits - 1; i >= 0; i--) send_bit(vt[t].bits[i]);
      pulse_load();
      tick(20);
      check_burst($sformatf("vec%0d", t), vt[t].exp_err);
      if (v_idx.size() == 8) begin
        chk($sformatf("vec%0d_idx0", t), 32'({v_addr[0][3:0], v_data[0][7:0]}), 32'({vt[t].a0, vt[t].d0}));
        chk($sformatf("vec%0d_idx7", t), 32'({v_addr[7][3:0], v_data[7][7:0]}), 32'({vt[t].a7, vt[t].d7}));
      end else begin
        chk($sformatf("vec%0d_idx0_7", t), 32'(v_idx.size()), 32'd8);
      end
    end

    // Overrun: LOAD rises again three cycles into the burst.
    clear_mon();
    for (int i = 127; i >= 0; i--) send_bit(vt[0].bits[i]);
    link.i_max7219_load = 1'b1;
    load_cyc = cyc;
    tick(1);
    link.i_max7219_load = 1'b0;
    tick(3);
    link.i_max7219_load = 1'b1;
    tick(H);
    link.i_max7219_load = 1'b0;
    tick(20);
    chk("ovr_count", 32'(ov_n), 32'd1);
    chk("ovr_err_no_bits", 32'(err_n), 32'd1);
    chk("ovr_total_frames", 32'(v_idx.size()), 32'd11);
    old_n = v_idx.size() - 8;
    if (old_n == 3) begin
      for (int i = 0; i < 3; i++) chk($sformatf("ovr_old%0d", i), 32'(v_idx[i]), 32'(i));
      chk("ovr_pulse_before_fresh", 32'(v_cyc[3] - ov_cyc), 32'd1);
      for (int i = 0; i < 8; i++) begin
        chk($sformatf("ovr_fresh%0d", i),
            {8'(v_idx[3+i]), 4'(v_addr[3+i]), 8'(v_data[3+i]), 12'(v_cyc[3+i] - v_cyc[3])},
            frame_word(i, i, exp_sr[16*i +: 16]));
      end
    end else begin
      chk("ovr_old_frames", 32'(old_n), 32'd3);
    end

    // Reset in the middle of a chain drops the 64 bits already shifted.
    clear_mon();
    for (int i = 0; i < 64; i++) send_bit(1'(i % 3));
    link.i_max7219_clk = 1'b0;
    rst_n = 1'b0;
    exp_sr = '0;
    tick(2);
    chk("midreset_outputs",
        32'({o_frame_valid, o_frame_idx, o_frame_addr, o_frame_data, o_busy, o_bit_cnt_err, o_overrun}),
        32'd0);
    rst_n = 1'b1;
    tick(3);
    chk("midreset_no_frames", 32'(v_idx.size()), 32'd0);
    for (int i = 127; i >= 0; i--) send_bit(vt[2].bits[i]);
    pulse_load();
    tick(20);
    check_burst("midreset", 0);

    // Back-to-back chains of pseudo-random words.
    clear_mon();
    lf = 16'hACE1;
    for (int c = 0; c < 3; c++) begin
      for (int j = 0; j < 8; j++) begin
        lf = {lf[14:0], lf[15] ^ lf[13] ^ lf[12] ^ lf[10]};
        exp_w[c*8 + (7 - j)] = lf;
        for (int b = 15; b >= 0; b--) send_bit(lf[b]);
      end
      pulse_load();
    end
    tick(20);
    chk("b2b_count", 32'(v_idx.size()), 32'd24);
    chk("b2b_err_ovr", 32'({err_n[15:0], ov_n[15:0]}), 32'd0);
    for (int f = 0; f < v_idx.size() && f < 24; f++) begin
      chk($sformatf("b2b_frame%0d", f),
          {8'(v_idx[f]), 4'(v_addr[f]), 8'(v_data[f]), 12'd0},
          frame_word(f % 8, 0, exp_w[f]));
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
